toggle_pulse_gen: RTL and testbench
===================================

TOGGLE_PULSE_GEN -- requirements
Module: toggle_pulse_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized cycles required to accept a level change; legal range 2..65535.
REQ-002 SHALL have parameter REPEAT_DELAY, default 64: cycles in HELD from the initial pulse to the first auto-repeat pulse; legal range >=2.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 16: cycles between subsequent auto-repeat pulses; legal range >=2.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port btn_in, input, 1: raw asynchronous, bouncing toggle-request input (active-high).
REQ-007 SHALL have port t_out, output, 1: registered one-cycle toggle pulse, driven directly into a downstream T flip-flop's t input.
REQ-008 SHALL have port btn_level, output, 1: registered debounced level of btn_in.

Function
REQ-009 SHALL pass btn_in through a two-flop synchronizer; only its output btn_s is used by the control logic.
REQ-010 SHALL implement FSM states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT with one debounce counter cnt sized $clog2(DEBOUNCE_CYCLES).
REQ-011 IDLE: btn_s=1 -> PRESS_WAIT with cnt=0; otherwise remain.
REQ-012 PRESS_WAIT: btn_s=0 -> IDLE (bounce rejected, no pulse); btn_s=1 and cnt=DEBOUNCE_CYCLES-1 -> HELD, asserting t_out and btn_level on that edge; otherwise cnt increments.
REQ-013 HELD: btn_s=0 -> RELEASE_WAIT with cnt=0.
REQ-014 RELEASE_WAIT: btn_s=1 -> HELD with no pulse (release bounce rejected); btn_s=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE, clearing btn_level on that edge; otherwise cnt increments.
REQ-015 Latency: with btn_in stable high from clock edge k onward (in IDLE), t_out SHALL be high for exactly the cycle following edge k+2+DEBOUNCE_CYCLES.
REQ-016 t_out SHALL be high for at most one consecutive cycle and SHALL be low in every state except on the entering-HELD edge and on auto-repeat edges.
REQ-017 Exactly one pulse SHALL be produced per accepted press, regardless of bounce count on press or release.

Reset
REQ-018 While reset=0: state=IDLE, cnt=0, repeat counter=0, synchronizer flops=0, t_out=0, btn_level=0, asynchronously.
REQ-019 Reset asserted mid-press SHALL discard the press; after release, a fresh full debounce SHALL be required.

Configuration
REQ-020 Macro TOGGLE_PULSE_GEN_AUTO_REPEAT_EN defined: in HELD a repeat counter SHALL run; t_out pulses REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles while in HELD.
REQ-021 With the macro defined: the repeat counter SHALL freeze in RELEASE_WAIT, resume on return to HELD, and clear on entry to IDLE.
REQ-022 Macro undefined: no repeat counter logic SHALL exist; REPEAT_DELAY/REPEAT_PERIOD SHALL be ignored; one pulse per press only.

Structure
REQ-023 Shared package toggle_pkg SHALL hold the FSM state enum typedef (tpg_state_t) and the default parameter constants.
REQ-024 Synchronizer SHALL be a sub-module sync2 (clk, reset, d, q), reusable elsewhere in the codebase.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4)
REQ-025 Clean press: btn_in 0->1 sampled at edge 10, held -> t_out=1 only in the cycle after edge 16; btn_level=1 from edge 16.
REQ-026 Bounce on press: btn_in high 2 cycles, low 1, then stable high -> no pulse during bounce; exactly one pulse, 6 edges after the final rising sample.
REQ-027 Release bounce: from HELD, btn_in low 2 cycles, high 1, low stable -> no extra t_out; btn_level falls 6 edges after the final falling sample.
REQ-028 Reset mid-operation: reset=0 asynchronously during PRESS_WAIT -> t_out=0, btn_level=0 immediately; no pulse after reset release while btn_in is still high until a full debounce completes.
REQ-029 Auto-repeat (macro defined): btn_in held high 30 cycles after the initial pulse -> pulses at +0, +8, +12, +16, +20, +24, +28; macro undefined -> single pulse only.
REQ-030 End-to-end: t_out drives a T flip-flop; 3 clean presses -> flip-flop q sequence 0->1->0->1.

Source files
------------

// File: rtl/toggle_pkg.sv
// Shared types and default constants for the toggle pulse generator.
`timescale 1ns/1ps
package toggle_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } tpg_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 64;
  localparam int DEF_REPEAT_PERIOD   = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; clears to 0 on reset.
`timescale 1ns/1ps
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/toggle_pulse_gen.sv
// Debounced button -> one-cycle toggle pulse for a downstream T flip-flop.
// Define TOGGLE_PULSE_GEN_AUTO_REPEAT_EN to add hold-to-repeat pulses while HELD.
`timescale 1ns/1ps
module toggle_pulse_gen
  import toggle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic t_out,
  output logic btn_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Illegal configurations show up as a named block in the elaborated hierarchy.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param_cfg
  end

  logic btn_s;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  tpg_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             t_out_q, t_out_d;
  logic             btn_level_q, btn_level_d;

`ifdef TOGGLE_PULSE_GEN_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD));

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             phase_q, phase_d;
  logic [RPT_W-1:0] rpt_last;
  logic             rpt_fire;

  // phase_q selects the first (long) delay vs. the steady repeat period.
  always_comb begin
    rpt_last = phase_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
    rpt_d    = rpt_q;
    phase_d  = phase_q;
    rpt_fire = 1'b0;
    case (state_q)
      IDLE: begin
        rpt_d   = '0;
        phase_d = 1'b0;
      end
      HELD: begin
        if (btn_s) begin
          if (rpt_q == rpt_last) begin
            rpt_fire = 1'b1;
            rpt_d    = '0;
            phase_d  = 1'b1;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      rpt_q   <= rpt_d;
      phase_q <= phase_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    t_out_d     = 1'b0;
    btn_level_d = btn_level_q;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = HELD;
          t_out_d     = 1'b1;
          btn_level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef TOGGLE_PULSE_GEN_AUTO_REPEAT_EN
        else begin
          t_out_d = rpt_fire;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          btn_level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      t_out_q     <= 1'b0;
      btn_level_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      t_out_q     <= t_out_d;
      btn_level_q <= btn_level_d;
    end
  end

  assign t_out     = t_out_q;
  assign btn_level = btn_level_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Scoreboard bench: a run-length debounce model predicts t_out/btn_level every cycle.
`timescale 1ns/1ps
module tb_toggle_pulse_gen;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b0;
  logic t_out, btn_level;

  toggle_pulse_gen #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .t_out     (t_out),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic t;
    logic lvl;
  } exp_t;

  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];
  int   cyc = 0;
  int   last_pulse = -1;
  int   pulse_cnt = 0;
  logic tff_q = 1'b0;
  logic tff_clr = 1'b0;

  // Downstream T flip-flop driven by t_out
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tff_clr) tff_q <= 1'b0;
    else if (t_out) tff_q <= ~tff_q;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: accepted level flips after D+1 consecutive disagreeing
  // synchronized samples; btn_s lags btn_in by two sampling edges.
  bit dl[$];
  bit level;
  int run;
  int held;

  task automatic model_clear();
    dl = '{1'b0, 1'b0};
    level = 1'b0;
    run = 0;
    held = 0;
  endtask

  task automatic model_step(output exp_t e);
    bit s;
    e = '0;
    if (!reset) begin
      model_clear();
      return;
    end
    s = dl.pop_front();
    dl.push_back(btn_in);
    if (s != level) begin
      run++;
      if (run == D + 1) begin
        level = s;
        run = 0;
        held = 0;
        if (s) e.t = 1'b1;
      end
    end else begin
`ifdef TOGGLE_PULSE_GEN_AUTO_REPEAT_EN
      if (level && run == 0) begin
        held++;
        if (held == RD || (held > RD && (held - RD) % RP == 0)) e.t = 1'b1;
      end
`endif
      run = 0;
    end
    e.lvl = level;
  endtask

  task automatic tick(input logic b);
    exp_t e;
    @(posedge clk);
    model_step(e);
    sb.push_back(e);
    #1 btn_in = b;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_t_out", t_out, 0);
    chk("async_rst_btn_level", btn_level, 0);
    model_clear();
    repeat (n) tick(btn_in);
    reset = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (t_out === 1'b1) begin
        last_pulse = cyc;
        pulse_cnt++;
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("t_out", t_out, e.t);
        chk("btn_level", btn_level, e.lvl);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int p;
    logic b;
    int len;
    model_clear();
    #1;
    chk("reset_t_out", t_out, 0);
    chk("reset_btn_level", btn_level, 0);
    repeat (3) tick(1'b0);
    reset = 1'b1;
    repeat (4) tick(1'b0);

    // Clean press latency
    last_pulse = -1;
    tick(1'b1);
    p = cyc;
    repeat (D + 5) tick(1'b1);
    chk("clean_press_latency", last_pulse, p + 3 + D);
    repeat (D + 4) tick(1'b0);

    // Press bounce: high 2, low 1, then stable high
    tick(1'b1); tick(1'b1); tick(1'b0);
    last_pulse = -1;
    tick(1'b1);
    p = cyc;
    repeat (D + 5) tick(1'b1);
    chk("bounce_press_latency", last_pulse, p + 3 + D);

    // Release bounce: low 2, high 1, then stable low
    tick(1'b0); tick(1'b0); tick(1'b1);
    repeat (D + 6) tick(1'b0);

    // Reset during PRESS_WAIT with button held through release
    tick(1'b1); tick(1'b1); tick(1'b1);
    last_pulse = -1;
    do_reset(2);
    p = cyc;
    repeat (D + 5) tick(1'b1);
    chk("post_reset_latency", last_pulse, p + 3 + D);

    // Reset while HELD must drop btn_level immediately
    do_reset(2);
    repeat (D + 4) tick(1'b0);

    // Long hold: 30 cycles after the initial pulse
    pulse_cnt = 0;
    tick(1'b1);
    repeat (34) tick(1'b1);
    repeat (D + 6) tick(1'b0);
`ifdef TOGGLE_PULSE_GEN_AUTO_REPEAT_EN
    chk("long_hold_pulses", pulse_cnt, 7);
`else
    chk("long_hold_pulses", pulse_cnt, 1);
`endif

    // T flip-flop end to end: three presses -> 1, 0, 1
    tff_clr = 1'b1;
    tick(1'b0);
    tff_clr = 1'b0;
    tick(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      repeat (D + 4) tick(1'b1);
      repeat (D + 4) tick(1'b0);
      chk("tff_q", tff_q, (i % 2 == 0) ? 1 : 0);
    end

    // Randomized bouncing segments with occasional resets
    b = 1'b0;
    for (int s = 0; s < 80; s++) begin
      b = ~b;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
      repeat (len) tick(b);
      if ($urandom_range(0, 24) == 0) do_reset($urandom_range(1, 3));
    end

    repeat (D + 6) tick(1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
